// File: rtl/i2s_dma_pkg.sv
// -----------------------------------------------------------------------------
// i2s_dma_pkg
// Shared types for the I2S DMA channel scheduler: the scheduler state
// encoding and the owner encoding used on dma_sel and inside the picker.
// No ports (package).
// -----------------------------------------------------------------------------
package i2s_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Owner encoding doubles as the bit index into the {capture, playback}
    // request vector, so req[owner] is the current owner's request.
    localparam logic OWNER_PLAYBACK = 1'b0;
    localparam logic OWNER_CAPTURE  = 1'b1;

endpackage

// File: rtl/i2s_rr_pick.sv
// -----------------------------------------------------------------------------
// i2s_rr_pick
// Combinational 2-way picker choosing the next owner of the DMA channel.
// A lone requester always wins; on a tie capture wins when i_prio is set,
// otherwise the requester that did not own the channel last wins.
//
// Ports:
//   i_req[1:0]    bit 0 = playback request, bit 1 = capture request
//   i_last_owner  owner of the most recently released grant
//   i_prio        1 = capture wins ties, 0 = round-robin
//   o_valid       at least one requester is high
//   o_owner       chosen owner (OWNER_PLAYBACK / OWNER_CAPTURE)
// -----------------------------------------------------------------------------
module i2s_rr_pick
    import i2s_dma_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    input  logic       i_prio,
    output logic       o_valid,
    output logic       o_owner
);

    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        o_valid = |i_req;
        o_owner = OWNER_PLAYBACK;
        case (i_req)
            2'b01:   o_owner = OWNER_PLAYBACK;
            2'b10:   o_owner = OWNER_CAPTURE;
            2'b11:   o_owner = i_prio ? OWNER_CAPTURE : ~i_last_owner;
            default: o_owner = OWNER_PLAYBACK;
        endcase
    end

endmodule

// File: rtl/i2s_dma_scheduler.sv
// -----------------------------------------------------------------------------
// i2s_dma_scheduler
// Shares one HPS DMA handshake channel between the I2S playback and capture
// request lines. Grants bursts of up to BURST_LEN acknowledged beats, each
// beat being REQ (wait for dma_ack) -> ACK (one-cycle ack to the owner) ->
// GAP (dead cycle so the requester's registered req can settle). A watchdog
// abandons a grant that sees no dma_ack for TIMEOUT cycles and raises a
// sticky timeout_err.
//
// Ports:
//   i_clk                rising-edge clock
//   i_reset              synchronous active-high reset
//   i_enable             permits new grants; low ends the burst at next GAP
//   i_cfg_capture_prio   1 = capture wins ties, 0 = round-robin
//   i_err_clear          pulse clearing o_timeout_err (set wins)
//   i_playback_dma_req   playback requester
//   i_capture_dma_req    capture requester
//   o_playback_dma_ack   one-cycle ack to playback
//   o_capture_dma_ack    one-cycle ack to capture
//   o_dma_req            request to the HPS DMA channel
//   i_dma_ack            ack from the HPS DMA channel (used only in REQ)
//   o_dma_sel            current owner, 0 = playback, 1 = capture
//   o_busy               high outside IDLE
//   o_timeout_err        sticky watchdog flag
// All outputs decode registers only; no input reaches an output directly.
// -----------------------------------------------------------------------------
module i2s_dma_scheduler
    import i2s_dma_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_cfg_capture_prio,
    input  logic i_err_clear,
    input  logic i_playback_dma_req,
    input  logic i_capture_dma_req,
    output logic o_playback_dma_ack,
    output logic o_capture_dma_ack,
    output logic o_dma_req,
    input  logic i_dma_ack,
    output logic o_dma_sel,
    output logic o_busy,
    output logic o_timeout_err
);

    localparam int unsigned       WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [7:0]        BEAT_LAST = 8'(BURST_LEN);

    state_e            r_state;
    logic              r_owner;
    logic              r_last_owner;
    logic [7:0]        r_beat_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout_err;

    state_e            w_state_nxt;
    logic              w_owner_nxt;
    logic              w_last_owner_nxt;
    logic [7:0]        w_beat_cnt_nxt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              w_err_set;

    logic [1:0]        w_req;
    logic              w_pick_valid;
    logic              w_pick_owner;
    logic              w_owner_req;

    assign w_req       = {i_capture_dma_req, i_playback_dma_req};
    assign w_owner_req = w_req[r_owner];

    i2s_rr_pick u_pick (
        .i_req        (w_req),
        .i_last_owner (r_last_owner),
        .i_prio       (i_cfg_capture_prio),
        .o_valid      (w_pick_valid),
        .o_owner      (w_pick_owner)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_err_set        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_enable && w_pick_valid) begin
                    w_owner_nxt    = w_pick_owner;
                    w_beat_cnt_nxt = '0;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack on the expiry cycle wins over the watchdog.
                if (i_dma_ack) begin
                    w_state_nxt = ST_ACK;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_err_set        = 1'b1;
                    w_last_owner_nxt = r_owner;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            ST_ACK: begin
                w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                w_state_nxt    = ST_GAP;
            end
            ST_GAP: begin
                if (r_beat_cnt == BEAT_LAST || !w_owner_req || !i_enable) begin
                    w_last_owner_nxt = r_owner;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, matching real flip-flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWNER_PLAYBACK;
            r_last_owner  <= OWNER_CAPTURE;
            r_beat_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            if (w_err_set) begin
                r_timeout_err <= 1'b1;
            end else if (i_err_clear) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign o_dma_req          = (r_state == ST_REQ);
    assign o_playback_dma_ack = (r_state == ST_ACK) && (r_owner == OWNER_PLAYBACK);
    assign o_capture_dma_ack  = (r_state == ST_ACK) && (r_owner == OWNER_CAPTURE);
    assign o_dma_sel          = r_owner;
    assign o_busy             = (r_state != ST_IDLE);
    assign o_timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_i2s_dma_scheduler.sv
// -----------------------------------------------------------------------------
// tb_i2s_dma_scheduler
// Directed scenarios with literal expectations, followed by a randomized run.
// A transaction-level model of the grant/beat rules predicts every output on
// every cycle after the first reset.
// -----------------------------------------------------------------------------
module tb_i2s_dma_scheduler;

    localparam int BURST = 4;
    localparam int TMO   = 16;

    logic clk;
    logic reset;
    logic enable;
    logic prio;
    logic err_clear;
    logic pb_req;
    logic cap_req;
    logic man_ack;
    logic dma_ack;
    logic pb_ack;
    logic cap_ack;
    logic dma_req;
    logic dma_sel;
    logic busy;
    logic terr;

    // DMA responder: 0 = manual, 1 = ack every REQ cycle, 2 = random ack in
    // REQ, 3 = random ack regardless of REQ.
    int   ack_mode;
    logic auto_ack;
    logic rnd_ack;
    logic spur_ack;

    int compared   = 0;
    int mismatched = 0;

    i2s_dma_scheduler #(
        .BURST_LEN (BURST),
        .TIMEOUT   (TMO)
    ) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_enable           (enable),
        .i_cfg_capture_prio (prio),
        .i_err_clear        (err_clear),
        .i_playback_dma_req (pb_req),
        .i_capture_dma_req  (cap_req),
        .o_playback_dma_ack (pb_ack),
        .o_capture_dma_ack  (cap_ack),
        .o_dma_req          (dma_req),
        .i_dma_ack          (dma_ack),
        .o_dma_sel          (dma_sel),
        .o_busy             (busy),
        .o_timeout_err      (terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        auto_ack = dma_req;
        rnd_ack  = dma_req && ($urandom_range(0, 3) != 0);
        spur_ack = $urandom_range(0, 1) == 1;
    end

    assign dma_ack = (ack_mode == 0) ? man_ack :
                     (ack_mode == 1) ? auto_ack :
                     (ack_mode == 2) ? rnd_ack : spur_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A grant is either absent or in one of three beat phases:
    // 0 = waiting for the DMA, 1 = acknowledging, 2 = settling.
    bit m_valid = 0;
    bit m_busy  = 0;
    int m_phase = 0;
    bit m_owner = 0;
    bit m_last  = 1;
    int m_beats = 0;
    int m_wait  = 0;
    bit m_err   = 0;
    bit m_set;

    // Monitor data for the directed scenarios.
    int cyc     = 0;
    int pb_cnt  = 0;
    int cap_cnt = 0;
    int pb_ack_cyc[$];
    bit grants[$];
    bit prev_busy = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_valid = 1;
            m_busy  = 0;
            m_phase = 0;
            m_owner = 0;
            m_last  = 1;
            m_beats = 0;
            m_wait  = 0;
            m_err   = 0;
        end else begin
            m_set = 0;
            if (!m_busy) begin
                if (enable && (pb_req || cap_req)) begin
                    if (pb_req && cap_req) m_owner = prio ? 1'b1 : !m_last;
                    else                   m_owner = cap_req;
                    m_busy  = 1;
                    m_phase = 0;
                    m_beats = 0;
                    m_wait  = 0;
                end
            end else if (m_phase == 0) begin
                if (dma_ack) begin
                    m_phase = 1;
                end else if (m_wait == TMO - 1) begin
                    m_busy = 0;
                    m_last = m_owner;
                    m_set  = 1;
                end else begin
                    m_wait++;
                end
            end else if (m_phase == 1) begin
                m_beats++;
                m_phase = 2;
            end else begin
                if (m_beats == BURST || !(m_owner ? cap_req : pb_req) || !enable) begin
                    m_busy = 0;
                    m_last = m_owner;
                end else begin
                    m_phase = 0;
                    m_wait  = 0;
                end
            end
            if (m_set)          m_err = 1;
            else if (err_clear) m_err = 0;
        end
        #1;
        if (m_valid) begin
            check("dma_req",  dma_req, m_busy && m_phase == 0);
            check("pb_ack",   pb_ack,  m_busy && m_phase == 1 && !m_owner);
            check("cap_ack",  cap_ack, m_busy && m_phase == 1 && m_owner);
            check("dma_sel",  dma_sel, m_owner);
            check("busy",     busy,    m_busy);
            check("timeout",  terr,    m_err);
            if (pb_ack) begin
                pb_cnt++;
                pb_ack_cyc.push_back(cyc);
            end
            if (cap_ack) cap_cnt++;
            if (busy && !prev_busy) grants.push_back(dma_sel);
            prev_busy = busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        pb_cnt  = 0;
        cap_cnt = 0;
        pb_ack_cyc.delete();
        grants.delete();
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic wait_busy(input logic v, input int budget, input string name);
        int k = 0;
        while (busy !== v && k < budget) begin
            tick(1);
            k++;
        end
        check(name, busy, v);
    endtask

    task automatic wait_req(input int budget, input string name);
        int k = 0;
        while (dma_req !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, dma_req, 1'b1);
    endtask

    task automatic wait_pb_cnt(input int n, input int budget, input string name);
        int k = 0;
        while (pb_cnt < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, pb_cnt, n);
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int k = 0;
        while (grants.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, grants.size(), n);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int k;
        reset = 1'b1; enable = 1'b0; prio = 1'b0; err_clear = 1'b0;
        pb_req = 1'b0; cap_req = 1'b0; man_ack = 1'b0; ack_mode = 1;
        tick(2);
        reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_req",  dma_req, 1'b0);
        check("rst_acks", {pb_ack, cap_ack}, 2'b00);
        check("rst_sel",  dma_sel, 1'b0);
        check("rst_err",  terr, 1'b0);

        // Single burst: playback held high, ack every REQ cycle.
        clear_mon();
        enable = 1'b1;
        pb_req = 1'b1;
        wait_pb_cnt(4, 40, "burst_acks");
        wait_busy(1'b0, 10, "burst_idle");
        check("burst_len", pb_cnt, 4);
        check("burst_cap", cap_cnt, 0);
        pb_req = 1'b0;
        for (int i = 0; i + 1 < pb_ack_cyc.size(); i++)
            check("burst_spacing", pb_ack_cyc[i+1] - pb_ack_cyc[i], 3);
        check("burst_grants", grants.size(), 1);
        if (grants.size() > 0) check("burst_sel", grants[0], 1'b0);
        tick(2);

        // Round-robin: fresh reset so playback wins the first tie.
        reset_pulse();
        clear_mon();
        pb_req = 1'b1; cap_req = 1'b1;
        wait_grants(3, 100, "rr_grants");
        if (grants.size() >= 3) begin
            check("rr_g0", grants[0], 1'b0);
            check("rr_g1", grants[1], 1'b1);
            check("rr_g2", grants[2], 1'b0);
        end
        check("rr_pb_cnt",  pb_cnt, 4);
        check("rr_cap_cnt", cap_cnt, 4);
        pb_req = 1'b0; cap_req = 1'b0;
        wait_busy(1'b0, 20, "rr_idle");

        // Capture priority.
        clear_mon();
        prio = 1'b1;
        pb_req = 1'b1; cap_req = 1'b1;
        tick(40);
        check("prio_pb_cnt", pb_cnt, 0);
        check("prio_cap_cnt_ge9", cap_cnt >= 9, 1'b1);
        foreach (grants[i]) check("prio_grant", grants[i], 1'b1);
        pb_req = 1'b0; cap_req = 1'b0; prio = 1'b0;
        wait_busy(1'b0, 20, "prio_idle");

        // Timeout: playback requests, DMA never answers.
        clear_mon();
        ack_mode = 0; man_ack = 1'b0;
        pb_req = 1'b1;
        wait_req(5, "tmo_grant");
        k = 0;
        while (dma_req && k < 40) begin
            tick(1);
            k++;
        end
        check("tmo_req_cycles", k, TMO);
        check("tmo_err", terr, 1'b1);
        check("tmo_no_ack", pb_cnt + cap_cnt, 0);
        cap_req = 1'b1;
        tick(1);
        check("tmo_next_sel", dma_sel, 1'b1);
        check("tmo_next_req", dma_req, 1'b1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("tmo_cleared", terr, 1'b0);
        ack_mode = 1;
        pb_req = 1'b0; cap_req = 1'b0;
        wait_busy(1'b0, 20, "tmo_idle");

        // Ack on the expiry cycle, then reset while in ACK.
        ack_mode = 0; man_ack = 1'b0;
        pb_req = 1'b1;
        wait_req(5, "sim_grant");
        tick(TMO - 1);
        check("sim_still_req", dma_req, 1'b1);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        check("sim_ack", pb_ack, 1'b1);
        check("sim_no_err", terr, 1'b0);
        check("sim_req_low", dma_req, 1'b0);
        reset = 1'b1; pb_req = 1'b0;
        tick(1);
        reset = 1'b0;
        check("rst_ack_outs", {pb_ack, cap_ack, dma_req, dma_sel, busy, terr}, 6'b0);
        ack_mode = 1;

        // Early release after the 2nd beat, then spurious acks in IDLE.
        clear_mon();
        pb_req = 1'b1;
        wait_pb_cnt(2, 30, "early_acks");
        pb_req = 1'b0;
        tick(2);
        check("early_idle", busy, 1'b0);
        check("early_cnt", pb_cnt, 2);
        ack_mode = 3;
        tick(20);
        check("spur_pb", pb_cnt, 2);
        check("spur_cap", cap_cnt, 0);
        check("spur_busy", busy, 1'b0);
        ack_mode = 1;

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) ack_mode = $urandom_range(0, 3);
            man_ack   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) pb_req  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) cap_req = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 99) == 0) prio   = ~prio;
            enable    = $urandom_range(0, 15) != 0;
            err_clear = $urandom_range(0, 39) == 0;
            reset     = $urandom_range(0, 299) == 0;
            tick(1);
        end
        reset = 1'b0; err_clear = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/i2s_dma_scheduler.md
# i2s_dma_scheduler

Shares the single SOCFPGA DMA peripheral handshake channel between the I2S playback and capture request lines. It sits between the I2S APB FIFO core's `playback_dma_req`/`capture_dma_req` outputs and the HPS DMA request/acknowledge pins. It grants the channel in bursts of up to `BURST_LEN` beats, using round-robin or capture-priority arbitration. A watchdog releases the channel if the DMA stops acknowledging.

## Interface
- `BURST_LEN`, 4: maximum acknowledged beats per grant; legal range 1..255.
- `TIMEOUT`, 1024: cycles in REQ without `dma_ack` before the grant is abandoned; minimum 2.
- `clk` in 1: interface clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high; one clock, no other clock domain.
- `enable` in 1: high permits new grants; low lets the current beat finish and then idles.
- `cfg_capture_prio` in 1: high makes capture win every tie; low selects round-robin.
- `err_clear` in 1: single-cycle pulse that clears `timeout_err`.
- `playback_dma_req` in 1: playback requester.
- `capture_dma_req` in 1: capture requester.
- `playback_dma_ack` out 1: one-cycle acknowledge to playback.
- `capture_dma_ack` out 1: one-cycle acknowledge to capture.
- `dma_req` out 1: request to the HPS DMA channel.
- `dma_ack` in 1: acknowledge from the HPS DMA channel.
- `dma_sel` out 1: current owner; 0 = playback, 1 = capture.
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- **States:** IDLE, REQ, ACK, GAP.
- **IDLE:**
  - `dma_req` is 0.
  - If `enable` is high and any requester is high, latch the owner, clear `beat_cnt`, clear `wait_cnt`, and go to REQ.
- **Owner choice:**
  - Only one requester high: that requester.
  - Both high with `cfg_capture_prio`=1: capture.
  - Both high otherwise: the requester that is not `last_owner`.
- **REQ:**
  - `dma_req`=1 and `dma_sel`=owner.
  - On `dma_ack`: go to ACK.
  - Otherwise `wait_cnt` increments. When `wait_cnt`==`TIMEOUT`-1: set `timeout_err`, set `last_owner`=owner, and go to IDLE with no ack to the requester.
- **ACK:**
  - `dma_req`=0.
  - The owner's `*_dma_ack` is 1 for exactly this cycle.
  - `beat_cnt` increments, then go to GAP.
- **GAP:**
  - One dead cycle so the requester's registered req can re-evaluate after its ack.
  - If `beat_cnt`==`BURST_LEN`, the owner's req is low, or `enable` is low: set `last_owner`=owner and go to IDLE.
  - Otherwise clear `wait_cnt` and go to REQ with the same owner.
- **Ignored `dma_ack`:** `dma_ack` in IDLE, ACK or GAP is ignored. It produces no ack to either requester and no error.
- **Owner req drops in REQ:** no effect. The grant stays until ack or timeout, because the DMA may already be committed.
- **`timeout_err`:** set has priority over `err_clear` in the same cycle. No other event clears it.
- **Widths:**
  - `beat_cnt` is 8 bits.
  - `wait_cnt` is $clog2(`TIMEOUT`) bits.
  - Comparisons are unsigned; no counter wraps in legal use.

## Timing
- **Reset values:** all outputs 0. State IDLE, counters 0, `last_owner`=capture, so playback wins the first round-robin tie.
- **Reset mid-operation:** the next cycle is IDLE with all outputs 0. No ack pulse is emitted and `timeout_err` is cleared.
- **Grant latency:** a request high in IDLE at cycle n gives `dma_req` and `dma_sel` valid at n+1.
- **Ack latency:** `dma_ack` at cycle m (in REQ) gives the owner ack at m+1 with `dma_req` low at m+1.
- **Burst throughput:** one beat every 3 cycles minimum (REQ, ACK, GAP), assuming `dma_ack` in the first REQ cycle.
- **Ack vs timeout:** `dma_ack` in the same cycle the timeout would fire wins. Go to ACK and leave `timeout_err` unchanged.
- **Output timing:** all outputs are registered or decoded directly from state/owner registers. There is no combinational path from any input to any output.

## Structure
- Package `i2s_dma_pkg` holds:
  - the state enum (IDLE, REQ, ACK, GAP);
  - owner constants `OWNER_PLAYBACK`=0 and `OWNER_CAPTURE`=1.
- One natural sub-module: `i2s_rr_pick`, a combinational 2-way picker.
  - Inputs: `req[1:0]`, `last_owner`, `prio`.
  - Outputs: `valid`, `owner`.
- The FSM, counters and error flag stay in the top module.

## Test plan
- **Single burst:** `BURST_LEN`=4, playback req held high, capture low, `dma_ack` in every REQ cycle.
  - Expect 4 `playback_dma_ack` pulses 3 cycles apart, `dma_sel`=0 throughout, then IDLE. The bench checks that `busy` drops.
- **Round-robin:** both reqs held high, `cfg_capture_prio`=0.
  - Expect grant order playback burst (4), capture burst (4), playback burst; `dma_sel` toggles at each IDLE.
- **Capture priority:** both reqs high, `cfg_capture_prio`=1.
  - Expect every grant to go to capture; playback gets no ack while capture req stays high.
- **Timeout:** `TIMEOUT`=16, playback req high, `dma_ack` never asserted.
  - Expect `dma_req` high 16 cycles, then low, `timeout_err`=1 and no ack.
  - If capture req is high, the next grant goes to capture.
  - `err_clear` then returns `timeout_err` to 0.
- **Simultaneous events:** `dma_ack` on the expiry cycle gives an ack and no error. Also assert `reset` in the ACK state.
  - Expect no ack pulse on the following cycle and all outputs 0.
- **Early release:** owner req drops after the 2nd beat.
  - Expect exit to IDLE at GAP after 2 acks. Spurious `dma_ack` pulses in IDLE produce no ack outputs.
